// File: rtl/sensor_merge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sensor_merge_pkg
// Description : Shared defaults, overrun-policy type and channel-index width
//               helper for the sample channel merger and its sub-blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package sensor_merge_pkg;

    // Default geometry of a merger instance.
    localparam int c_DEFAULT_DATA_WIDTH = 12;
    localparam int c_DEFAULT_CHANNELS   = 4;
    localparam int c_DEFAULT_OVERWRITE  = 1;

    // What happens to the held sample when a channel is re-strobed while
    // its previous sample is still waiting for the output.
    typedef enum logic {
        POLICY_KEEP      = 1'b0,
        POLICY_OVERWRITE = 1'b1
    } overrun_policy_e;

    // Width of a channel index; a single channel still gets one bit so the
    // index port never collapses to zero width.
    function automatic int ch_width(input int channels);
        return (channels <= 1) ? 1 : $clog2(channels);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_channel_merger_if.sv
`default_nettype none
// ============================================================================
// Module      : sample_channel_merger_if
// Description : Bundles the per-channel strobe/data inputs, the output
//               valid/ready stream and the overrun status of the merger.
//               The merger uses the slave view, its environment the master.
// Revision    : 1.0 - initial release
// ============================================================================
interface sample_channel_merger_if
    import sensor_merge_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int CHANNELS   = c_DEFAULT_CHANNELS
);
    localparam int c_CH_W = ch_width(CHANNELS);

    logic [CHANNELS-1:0]            CHANGE_FLAG_IN;
    logic [CHANNELS*DATA_WIDTH-1:0] DATA_IN;
    logic                           OUT_VALID;
    logic                           OUT_READY;
    logic [c_CH_W-1:0]              OUT_CHANNEL;
    logic [DATA_WIDTH-1:0]          OUT_DATA;
    logic [CHANNELS-1:0]            OVERRUN;
    logic                           OVERRUN_CLEAR;

    // Merger side: consumes strobes and data, produces the merged stream.
    modport slave (
        input  CHANGE_FLAG_IN,
        input  DATA_IN,
        input  OUT_READY,
        input  OVERRUN_CLEAR,
        output OUT_VALID,
        output OUT_CHANNEL,
        output OUT_DATA,
        output OVERRUN
    );

    // Environment side: sample producers plus the downstream consumer.
    modport master (
        output CHANGE_FLAG_IN,
        output DATA_IN,
        output OUT_READY,
        output OVERRUN_CLEAR,
        input  OUT_VALID,
        input  OUT_CHANNEL,
        input  OUT_DATA,
        input  OVERRUN
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin selector. Picks the first requester strictly
//               after the previously granted index (wrapping), and moves the
//               pointer to the winner only when the grant is consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import sensor_merge_pkg::*;
#(
    parameter  int CHANNELS = c_DEFAULT_CHANNELS,
    localparam int c_CH_W   = ch_width(CHANNELS)
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic [CHANNELS-1:0] i_req,
    input  wire logic                i_advance,
    output logic      [CHANNELS-1:0] o_grant,
    output logic      [c_CH_W-1:0]   o_index
);

    // One spare bit so last + offset never overflows before the wrap.
    localparam int c_SUM_W = c_CH_W + 1;

    logic [c_CH_W-1:0] r_last;
    logic              w_any;

    assign w_any = |i_req;

    // Scan offsets from farthest to nearest so the nearest requester after
    // the last grant is the one left standing.
    always_comb begin
        logic [c_SUM_W-1:0] v_sum;
        logic [c_CH_W-1:0]  v_cand;
        o_grant = '0;
        o_index = '0;
        v_sum   = '0;
        v_cand  = '0;
        for (int k = CHANNELS; k >= 1; k--) begin
            v_sum = {1'b0, r_last} + c_SUM_W'(k);
            if (v_sum >= c_SUM_W'(CHANNELS)) begin
                v_sum = v_sum - c_SUM_W'(CHANNELS);
            end
            v_cand = v_sum[c_CH_W-1:0];
            if (i_req[v_cand]) begin
                o_grant         = '0;
                o_grant[v_cand] = 1'b1;
                o_index         = v_cand;
            end
        end
    end

    // Remember the consumed winner so the next search starts just past it;
    // after reset the pointer sits on the last channel so channel 0 leads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= c_CH_W'(CHANNELS - 1);
        end else if (i_advance && w_any) begin
            r_last <= o_index;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sample_channel_merger.sv
`default_nettype none
// ============================================================================
// Module      : sample_channel_merger
// Description : Merges CHANNELS independent sample strobes into one
//               valid/ready stream tagged with the source channel. Each
//               channel buffers one pending sample; re-strobes before the
//               sample leaves raise a sticky overrun flag and either replace
//               or drop the new value depending on OVERWRITE.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_channel_merger
    import sensor_merge_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int CHANNELS   = c_DEFAULT_CHANNELS,
    parameter int OVERWRITE  = c_DEFAULT_OVERWRITE
) (
    input wire logic          CLK,
    input wire logic          RESET,
    sample_channel_merger_if.slave bus
);

    localparam int              c_CH_W   = ch_width(CHANNELS);
    localparam overrun_policy_e c_POLICY = (OVERWRITE != 0) ? POLICY_OVERWRITE
                                                            : POLICY_KEEP;

    // Per-channel buffer state.
    logic [CHANNELS-1:0]   r_pending;
    logic [DATA_WIDTH-1:0] r_hold [CHANNELS];
    logic [CHANNELS-1:0]   r_overrun;

    // Output register.
    logic                  r_out_valid;
    logic [c_CH_W-1:0]     r_out_channel;
    logic [DATA_WIDTH-1:0] r_out_data;

    // Datapath / control wires.
    logic [DATA_WIDTH-1:0] w_slice [CHANNELS];
    logic                  w_load;
    logic                  w_any_pending;
    logic                  w_advance;
    logic [CHANNELS-1:0]   w_grant;
    logic [c_CH_W-1:0]     w_index;
    logic [CHANNELS-1:0]   w_taken;
    logic [CHANNELS-1:0]   w_capture;
    logic [CHANNELS-1:0]   w_new_overrun;

    // Unpack the flat input bus into per-channel samples.
    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_slice
            assign w_slice[g] = bus.DATA_IN[g*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // The output register may take a new sample when it is empty or its
    // current sample is being accepted this cycle.
    assign w_load        = !r_out_valid || bus.OUT_READY;
    assign w_any_pending = |r_pending;
    assign w_advance     = w_load && w_any_pending;

    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_arbiter (
        .clk       (CLK),
        .rst       (RESET),
        .i_req     (r_pending),
        .i_advance (w_advance),
        .o_grant   (w_grant),
        .o_index   (w_index)
    );

    // A channel is "taken" when its pending sample moves to the output.
    // Taking frees the slot in the same cycle, so a simultaneous strobe on
    // that channel is a clean capture rather than an overrun.
    assign w_taken       = w_advance ? w_grant : '0;
    assign w_capture     = bus.CHANGE_FLAG_IN & (~r_pending | w_taken);
    assign w_new_overrun = bus.CHANGE_FLAG_IN & r_pending & ~w_taken;

    // Per-channel pending bit and hold register: strobes always leave the
    // channel pending; only a grant without a strobe empties it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pending <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            r_pending <= (r_pending & ~w_taken) | bus.CHANGE_FLAG_IN;
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_capture[i] ||
                    (w_new_overrun[i] && (c_POLICY == POLICY_OVERWRITE))) begin
                    r_hold[i] <= w_slice[i];
                end
            end
        end
    end

    // Output register: reload on every loadable cycle, reading the hold
    // register before any same-cycle capture replaces it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_out_valid   <= 1'b0;
            r_out_channel <= '0;
            r_out_data    <= '0;
        end else if (w_load) begin
            r_out_valid <= w_any_pending;
            if (w_any_pending) begin
                r_out_channel <= w_index;
                r_out_data    <= r_hold[w_index];
            end
        end
    end

    // Sticky overrun flags; a new overrun beats a coincident clear.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_overrun <= '0;
        end else begin
            r_overrun <= (bus.OVERRUN_CLEAR ? '0 : r_overrun) | w_new_overrun;
        end
    end

    assign bus.OUT_VALID   = r_out_valid;
    assign bus.OUT_CHANNEL = r_out_channel;
    assign bus.OUT_DATA    = r_out_data;
    assign bus.OVERRUN     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sample_channel_merger.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_channel_merger
// Description : Self-checking bench for sample_channel_merger. Two DUTs
//               (replace and keep policies) see identical stimulus and are
//               compared against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_channel_merger;

    localparam int DW = 12;
    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] flag;
    logic [CH*DW-1:0] din;
    logic          ready;
    logic          clr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sample_channel_merger_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) bus_ow ();
    sample_channel_merger_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) bus_kp ();

    assign bus_ow.CHANGE_FLAG_IN = flag;
    assign bus_ow.DATA_IN        = din;
    assign bus_ow.OUT_READY      = ready;
    assign bus_ow.OVERRUN_CLEAR  = clr;
    assign bus_kp.CHANGE_FLAG_IN = flag;
    assign bus_kp.DATA_IN        = din;
    assign bus_kp.OUT_READY      = ready;
    assign bus_kp.OVERRUN_CLEAR  = clr;

    sample_channel_merger #(.DATA_WIDTH(DW), .CHANNELS(CH), .OVERWRITE(1)) dut_ow (
        .CLK (clk), .RESET (rst), .bus (bus_ow)
    );
    sample_channel_merger #(.DATA_WIDTH(DW), .CHANNELS(CH), .OVERWRITE(0)) dut_kp (
        .CLK (clk), .RESET (rst), .bus (bus_kp)
    );

    // Reference model, index 0 = replace policy, 1 = keep policy.
    bit m_pend  [2][CH];
    int m_hold  [2][CH];
    bit m_ovr   [2][CH];
    int m_last  [2];
    bit m_valid [2];
    int m_ch    [2];
    int m_data  [2];

    function automatic int slice_of(input int c);
        return int'(din[c*DW +: DW]);
    endfunction

    function automatic logic [CH-1:0] m_ovr_vec(input int p);
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = m_ovr[p][c];
        return v;
    endfunction

    // One clock of the model: a free or draining output picks the next
    // waiting channel after the last one served; then each strobe lands.
    task automatic model_step(input int p);
        int take;
        int c;
        bit nov [CH];
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                m_pend[p][i] = 0; m_hold[p][i] = 0; m_ovr[p][i] = 0;
            end
            m_last[p] = CH - 1; m_valid[p] = 0; m_ch[p] = 0; m_data[p] = 0;
            return;
        end
        take = -1;
        if (!m_valid[p] || ready) begin
            for (int k = 1; k <= CH; k++) begin
                c = (m_last[p] + k) % CH;
                if (take < 0 && m_pend[p][c]) take = c;
            end
            if (take >= 0) begin
                m_valid[p] = 1; m_ch[p] = take; m_data[p] = m_hold[p][take];
                m_last[p] = take;
            end else begin
                m_valid[p] = 0;
            end
        end
        for (int i = 0; i < CH; i++) begin
            nov[i] = 0;
            if (flag[i]) begin
                if (!m_pend[p][i] || take == i) begin
                    m_hold[p][i] = slice_of(i);
                    m_pend[p][i] = 1;
                end else begin
                    nov[i] = 1;
                    if (p == 0) m_hold[p][i] = slice_of(i);
                end
            end else if (take == i) begin
                m_pend[p][i] = 0;
            end
        end
        for (int i = 0; i < CH; i++) begin
            m_ovr[p][i] = (clr ? 1'b0 : m_ovr[p][i]) | nov[i];
        end
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; flag = '0; din = '0; ready = 0; clr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic set_ch(input int c, input int v);
        flag[c] = 1'b1;
        din[c*DW +: DW] = DW'(v);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; flag = '1; din = {CH{12'hFFF}}; ready = 1; clr = 1;
        tick();
        tick();
        checks++;
        if ({bus_ow.OUT_VALID, bus_ow.OUT_CHANNEL, bus_ow.OUT_DATA, bus_ow.OVERRUN} !== '0) begin
            errors++;
            $display("FAIL reset_state_ow got v=%0b ch=%0d d=%h ovr=%b want all zero",
                     bus_ow.OUT_VALID, bus_ow.OUT_CHANNEL, bus_ow.OUT_DATA, bus_ow.OVERRUN);
        end
        checks++;
        if ({bus_kp.OUT_VALID, bus_kp.OUT_CHANNEL, bus_kp.OUT_DATA, bus_kp.OVERRUN} !== '0) begin
            errors++;
            $display("FAIL reset_state_kp got v=%0b ch=%0d d=%h ovr=%b want all zero",
                     bus_kp.OUT_VALID, bus_kp.OUT_CHANNEL, bus_kp.OUT_DATA, bus_kp.OVERRUN);
        end
        idle_inputs();
        ready = 1;
        tick();
        checks++;
        if (bus_ow.OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_valid got %0b want 0", bus_ow.OUT_VALID);
        end
    endtask

    task automatic test_single_latency();
        do_reset();
        ready = 1;
        set_ch(2, 'hABC);
        tick();
        flag = '0;
        checks++;
        if (bus_ow.OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL latency_early_valid got %0b want 0", bus_ow.OUT_VALID);
        end
        tick();
        checks++;
        if ({bus_ow.OUT_VALID, bus_ow.OUT_CHANNEL, bus_ow.OUT_DATA} !== {1'b1, 2'd2, 12'hABC}) begin
            errors++;
            $display("FAIL latency_output got v=%0b ch=%0d d=%h want v=1 ch=2 d=abc",
                     bus_ow.OUT_VALID, bus_ow.OUT_CHANNEL, bus_ow.OUT_DATA);
        end
        tick();
        checks++;
        if (bus_ow.OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL latency_one_cycle got valid %0b want 0", bus_ow.OUT_VALID);
        end
    endtask

    task automatic test_all_four();
        do_reset();
        ready = 1;
        for (int c = 0; c < CH; c++) set_ch(c, 'h100 + c);
        tick();
        flag = '0;
        for (int k = 0; k < CH; k++) begin
            tick();
            checks++;
            if ({bus_ow.OUT_VALID, bus_ow.OUT_CHANNEL, bus_ow.OUT_DATA} !==
                {1'b1, 2'(k), 12'(256 + k)}) begin
                errors++;
                $display("FAIL all_four_slot%0d got v=%0b ch=%0d d=%h want v=1 ch=%0d d=%h",
                         k, bus_ow.OUT_VALID, bus_ow.OUT_CHANNEL, bus_ow.OUT_DATA, k, 256 + k);
            end
        end
        tick();
        checks++;
        if ({bus_ow.OUT_VALID, bus_ow.OVERRUN} !== 5'b0) begin
            errors++;
            $display("FAIL all_four_drain got v=%0b ovr=%b want v=0 ovr=0000",
                     bus_ow.OUT_VALID, bus_ow.OVERRUN);
        end
    endtask

    task automatic test_overrun_policy();
        do_reset();
        set_ch(1, 'h111); tick(); flag = '0;
        tick();
        set_ch(1, 'h222); tick(); flag = '0;
        checks++;
        if ({bus_ow.OUT_VALID, bus_ow.OUT_DATA, bus_ow.OVERRUN} !== {1'b1, 12'h111, 4'b0000}) begin
            errors++;
            $display("FAIL overrun_hold_before got v=%0b d=%h ovr=%b want v=1 d=111 ovr=0000",
                     bus_ow.OUT_VALID, bus_ow.OUT_DATA, bus_ow.OVERRUN);
        end
        tick();
        set_ch(1, 'h333); tick(); flag = '0;
        checks++;
        if ({bus_ow.OUT_DATA, bus_ow.OVERRUN} !== {12'h111, 4'b0010}) begin
            errors++;
            $display("FAIL overrun_flag_ow got d=%h ovr=%b want d=111 ovr=0010",
                     bus_ow.OUT_DATA, bus_ow.OVERRUN);
        end
        checks++;
        if ({bus_kp.OUT_DATA, bus_kp.OVERRUN} !== {12'h111, 4'b0010}) begin
            errors++;
            $display("FAIL overrun_flag_kp got d=%h ovr=%b want d=111 ovr=0010",
                     bus_kp.OUT_DATA, bus_kp.OVERRUN);
        end
        ready = 1;
        tick();
        checks++;
        if ({bus_ow.OUT_VALID, bus_ow.OUT_CHANNEL, bus_ow.OUT_DATA} !== {1'b1, 2'd1, 12'h333}) begin
            errors++;
            $display("FAIL overrun_replace got v=%0b ch=%0d d=%h want v=1 ch=1 d=333",
                     bus_ow.OUT_VALID, bus_ow.OUT_CHANNEL, bus_ow.OUT_DATA);
        end
        checks++;
        if ({bus_kp.OUT_VALID, bus_kp.OUT_CHANNEL, bus_kp.OUT_DATA} !== {1'b1, 2'd1, 12'h222}) begin
            errors++;
            $display("FAIL overrun_keep got v=%0b ch=%0d d=%h want v=1 ch=1 d=222",
                     bus_kp.OUT_VALID, bus_kp.OUT_CHANNEL, bus_kp.OUT_DATA);
        end
        tick();
        checks++;
        if ({bus_ow.OUT_VALID, bus_ow.OVERRUN} !== {1'b0, 4'b0010}) begin
            errors++;
            $display("FAIL overrun_sticky got v=%0b ovr=%b want v=0 ovr=0010",
                     bus_ow.OUT_VALID, bus_ow.OVERRUN);
        end
    endtask

    task automatic test_fairness();
        int seen;
        seen = -1;
        do_reset();
        ready = 1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            set_ch(0, cyc);
            if (cyc == 3) set_ch(3, 'h3C3);
            tick();
            flag = '0;
            if (seen < 0 && bus_ow.OUT_VALID === 1'b1 && bus_ow.OUT_CHANNEL === 2'd3) seen = cyc;
            checks++;
            if (bus_ow.OUT_VALID !== 1'(m_valid[0]) ||
                (m_valid[0] && ({bus_ow.OUT_CHANNEL, bus_ow.OUT_DATA} !==
                                {2'(m_ch[0]), 12'(m_data[0])}))) begin
                errors++;
                $display("FAIL fairness_stream cyc%0d got v=%0b ch=%0d d=%h want v=%0b ch=%0d d=%h",
                         cyc, bus_ow.OUT_VALID, bus_ow.OUT_CHANNEL, bus_ow.OUT_DATA,
                         m_valid[0], m_ch[0], m_data[0]);
            end
        end
        checks++;
        if (seen < 0 || seen - 3 > 4) begin
            errors++;
            $display("FAIL fairness_ch3_latency got %0d cycles want <= 4", (seen < 0) ? 99 : seen - 3);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        set_ch(0, 'h5A0); set_ch(1, 'h5A1); set_ch(2, 'h5A2);
        tick();
        flag = '0;
        tick();
        checks++;
        if (bus_ow.OUT_VALID !== 1'b1) begin
            errors++;
            $display("FAIL midflight_setup got valid %0b want 1", bus_ow.OUT_VALID);
        end
        rst = 1; flag = '1; ready = 1; clr = 1;
        tick();
        checks++;
        if ({bus_ow.OUT_VALID, bus_ow.OUT_CHANNEL, bus_ow.OUT_DATA, bus_ow.OVERRUN} !== '0) begin
            errors++;
            $display("FAIL midflight_reset got v=%0b ch=%0d d=%h ovr=%b want all zero",
                     bus_ow.OUT_VALID, bus_ow.OUT_CHANNEL, bus_ow.OUT_DATA, bus_ow.OVERRUN);
        end
        idle_inputs();
        ready = 1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (bus_ow.OUT_VALID !== 1'b0) begin
                errors++;
                $display("FAIL midflight_stale cyc%0d got valid %0b ch=%0d d=%h want 0",
                         k, bus_ow.OUT_VALID, bus_ow.OUT_CHANNEL, bus_ow.OUT_DATA);
            end
        end
    endtask

    task automatic test_clear_collision();
        do_reset();
        set_ch(0, 'h010); set_ch(2, 'h012); set_ch(3, 'h013);
        tick(); flag = '0;
        tick();
        set_ch(0, 'h020); set_ch(3, 'h023);
        tick(); flag = '0;
        set_ch(0, 'h030);
        tick(); flag = '0;
        checks++;
        if (bus_ow.OVERRUN !== 4'b1001) begin
            errors++;
            $display("FAIL clear_setup got ovr=%b want 1001", bus_ow.OVERRUN);
        end
        set_ch(2, 'h042); clr = 1;
        tick(); flag = '0; clr = 0;
        checks++;
        if (bus_ow.OVERRUN !== 4'b0100) begin
            errors++;
            $display("FAIL clear_set_wins_ow got ovr=%b want 0100", bus_ow.OVERRUN);
        end
        checks++;
        if (bus_kp.OVERRUN !== 4'b0100) begin
            errors++;
            $display("FAIL clear_set_wins_kp got ovr=%b want 0100", bus_kp.OVERRUN);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int c = 0; c < CH; c++) flag[c] = ($urandom_range(0, 2) == 0);
            for (int c = 0; c < CH; c++) din[c*DW +: DW] = DW'($urandom);
            ready = ($urandom_range(0, 9) < 7);
            clr   = ($urandom_range(0, 19) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            tick();
            for (int p = 0; p < 2; p++) begin
                logic          a_v;
                logic [1:0]    a_ch;
                logic [DW-1:0] a_d;
                logic [CH-1:0] a_o;
                a_v  = (p == 0) ? bus_ow.OUT_VALID   : bus_kp.OUT_VALID;
                a_ch = (p == 0) ? bus_ow.OUT_CHANNEL : bus_kp.OUT_CHANNEL;
                a_d  = (p == 0) ? bus_ow.OUT_DATA    : bus_kp.OUT_DATA;
                a_o  = (p == 0) ? bus_ow.OVERRUN     : bus_kp.OVERRUN;
                checks++;
                if (a_v !== 1'(m_valid[p]) || a_o !== m_ovr_vec(p) ||
                    (m_valid[p] && ({a_ch, a_d} !== {2'(m_ch[p]), 12'(m_data[p])}))) begin
                    errors++;
                    $display("FAIL random_p%0d cyc%0d got v=%0b ch=%0d d=%h ovr=%b want v=%0b ch=%0d d=%h ovr=%b",
                             p, cyc, a_v, a_ch, a_d, a_o,
                             m_valid[p], m_ch[p], m_data[p], m_ovr_vec(p));
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_latency();
        test_all_four();
        test_overrun_policy();
        test_fairness();
        test_reset_midflight();
        test_clear_collision();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sample_channel_merger.md
SAMPLE_CHANNEL_MERGER -- requirements
Module: sample_channel_merger

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, bits per sample.
REQ-002 SHALL have parameter CHANNELS, default 4, number of input channels (1..16).
REQ-003 SHALL have parameter OVERWRITE, default 1, overrun policy (1 = newest replaces pending, 0 = pending kept, new dropped).
REQ-004 SHALL have port CLK  in  1  single clock; all logic on posedge.
REQ-005 SHALL have port RESET  in  1  synchronous active-high reset.
REQ-006 SHALL have port CHANGE_FLAG_IN  in  CHANNELS  per-channel one-cycle "new sample" strobe.
REQ-007 SHALL have port DATA_IN  in  CHANNELS*DATA_WIDTH  flat sample bus; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port OUT_VALID  out  1  output sample present.
REQ-009 SHALL have port OUT_READY  in  1  consumer accepts when OUT_VALID & OUT_READY.
REQ-010 SHALL have port OUT_CHANNEL  out  CH_W  source channel index; CH_W = max(1, clog2(CHANNELS)).
REQ-011 SHALL have port OUT_DATA  out  DATA_WIDTH  sample value.
REQ-012 SHALL have port OVERRUN  out  CHANNELS  sticky per-channel overrun flags.
REQ-013 SHALL have port OVERRUN_CLEAR  in  1  clears all OVERRUN bits.

Function
REQ-014 SHALL keep, per channel, a pending bit and a DATA_WIDTH hold register.
REQ-015 SHALL, on CHANGE_FLAG_IN[i]=1 with channel i not pending, or pending but granted this cycle, capture DATA_IN slice i into hold register and set pending[i].
REQ-016 SHALL, on CHANGE_FLAG_IN[i]=1 with channel i pending and not granted this cycle, set OVERRUN[i]; replace hold data if OVERWRITE=1, else keep it.
REQ-017 SHALL treat output register as loadable when OUT_VALID=0 or (OUT_VALID & OUT_READY).
REQ-018 SHALL, when loadable and any pending bit set, grant one channel round-robin starting at last granted index + 1 (wrap CHANNELS-1 -> 0), load OUT_CHANNEL/OUT_DATA, set OUT_VALID, clear granted pending bit.
REQ-019 SHALL deassert OUT_VALID after a handshake when nothing is pending.
REQ-020 SHALL hold OUT_VALID, OUT_CHANNEL, OUT_DATA stable while OUT_VALID=1 and OUT_READY=0.
REQ-021 SHALL give latency: strobe at edge N -> OUT_VALID high after edge N+1 (empty pipeline, output loadable).
REQ-022 SHALL sustain one sample per cycle with OUT_READY held high.
REQ-023 SHALL, on simultaneous strobe and grant for the same channel, output old hold data and retain new data as pending, with no overrun.
REQ-024 SHALL, on OVERRUN_CLEAR coinciding with a new overrun on channel i, leave OVERRUN[i]=1 (set wins); other bits clear.
REQ-025 SHALL with CHANNELS=1 drive OUT_CHANNEL=0 and behave as single-entry buffer plus output register.

Reset
REQ-026 SHALL on RESET=1 at a clock edge clear OUT_VALID, OUT_CHANNEL, OUT_DATA, OVERRUN, all pending bits and hold registers to 0, and set last-grant pointer to CHANNELS-1 (channel 0 first).
REQ-027 SHALL ignore CHANGE_FLAG_IN, OUT_READY, OVERRUN_CLEAR during reset cycles; no pre-reset sample ever appears on output.

Structure
REQ-028 SHALL place CH_W computation function and parameter defaults in shared package sensor_merge_pkg.
REQ-029 SHALL implement grant selection in sub-module rr_arbiter (parameter CHANNELS; inputs request vector, advance enable; outputs one-hot grant, index).

Verification (CHANNELS=4, DATA_WIDTH=12)
REQ-030 SHALL cover: ch2 strobe 0xABC at cycle 0, READY=1 -> cycle 2 OUT_VALID=1, OUT_CHANNEL=2, OUT_DATA=0xABC, one cycle only.
REQ-031 SHALL cover: all four strobed cycle 0 with 0x100..0x103, READY=1 -> channels 0,1,2,3 on cycles 2..5, OVERRUN=0.
REQ-032 SHALL cover: READY=0, ch1 strobes 0x111, 0x222, 0x333 on cycles 0,2,4 -> OUT_DATA held 0x111, OVERRUN[1]=1; READY=1 then delivers 0x111 then 0x333 (OVERWRITE=1) or 0x222 (OVERWRITE=0).
REQ-033 SHALL cover: ch0 strobed every cycle, ch3 strobed once, READY=1 -> ch3 output within 4 cycles of pending; no ch0 overrun.
REQ-034 SHALL cover: three pending plus OUT_VALID=1, RESET for 1 cycle -> all outputs 0 next cycle; no old data after release.
REQ-035 SHALL cover: OVERRUN_CLEAR same cycle as new ch2 overrun with OVERRUN=0b1001 -> OVERRUN=0b0100.
